// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int STAT_W = 16;

  // A single requester still needs a 1-bit ID field.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] sel;

  always_comb begin
    req_hi = '0;
    for (int i = 0; i < NUM_REQ; i++) req_hi[i] = req[i] && (ID_W'(i) >= ptr);
    // Nothing at/after the pointer means the search wraps to the lowest index.
    sel = (|req_hi) ? req_hi : req;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (sel[i]) gnt_idx = ID_W'(i);
    gnt_any = |req;
    gnt = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one pipelined multiplier among NUM_REQ requesters, tagging results by ID.
// Optional grant counters enabled with `define MULT_ARB_STATS_EN.
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W1      = 8,
  parameter int W2      = 8,
  parameter int MUL_LAT = 2,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*W1-1:0]     req_a,
  input  logic [NUM_REQ*W2-1:0]     req_b,
  output logic [W1-1:0]             mul_a,
  output logic [W2-1:0]             mul_b,
  output logic                      mul_en,
  input  logic [W1+W2-1:0]          mul_sum,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [W1+W2-1:0]          rsp_sum,
  output logic                      busy,
  output logic [NUM_REQ*STAT_W-1:0] stat_grants
);

  state_e                        state_q, state_d;
  logic [ID_W-1:0]               ptr_q, ptr_d;
  logic [W1-1:0]                 mul_a_q, mul_a_d;
  logic [W2-1:0]                 mul_b_q, mul_b_d;
  logic                          iss_vld_q, iss_vld_d;
  logic [ID_W-1:0]               iss_id_q, iss_id_d;
  logic [MUL_LAT-1:0]            tag_vld_q, tag_vld_d;
  logic [MUL_LAT-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]               rsp_id_q, rsp_id_d;
  logic [W1+W2-1:0]              rsp_sum_q, rsp_sum_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               xfer;
  logic               pipe_busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // The issue stage counts as in flight so DRAIN never drops the multiplier enable early.
  assign pipe_busy = iss_vld_q | (|tag_vld_q);
  assign xfer      = (state_q == ST_RUN) && gnt_any;
  assign req_ready = (state_q == ST_RUN) ? gnt : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: if (en) state_d = ST_RUN;
                else if (!pipe_busy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    iss_vld_d = xfer;
    iss_id_d  = iss_id_q;
    if (xfer) begin
      ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      mul_a_d  = req_a[gnt_idx*W1 +: W1];
      mul_b_d  = req_b[gnt_idx*W2 +: W2];
      iss_id_d = gnt_idx;
    end
    tag_vld_d[0] = iss_vld_q;
    tag_id_d[0]  = iss_id_q;
    for (int i = 1; i < MUL_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    rsp_valid_d = tag_vld_q[MUL_LAT-1];
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    if (tag_vld_q[MUL_LAT-1]) begin
      rsp_id_d  = tag_id_q[MUL_LAT-1];
      rsp_sum_d = mul_sum;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      iss_vld_q   <= 1'b0;
      iss_id_q    <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      iss_vld_q   <= iss_vld_d;
      iss_id_q    <= iss_id_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_en    = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign busy      = (state_q != ST_IDLE) | pipe_busy;

`ifdef MULT_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (xfer && gnt[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign stat_grants = cnt_q;
`else
  assign stat_grants = '0;
`endif

endmodule
